// File: rtl/core_mul_pkg.sv
`default_nettype none
// ============================================================================
// Module      : core_mul_pkg
// Description : Shared types and helpers for the iterative multiplier.
//               word_t      - 32-bit data word
//               dword_t     - 64-bit double word (product / accumulator)
//               mul_state_t - sequencer states (IDLE, RUN, FINISH)
//               abs_word    - magnitude of a word as a 32-bit unsigned value
// Revision    : 1.0 - initial release
// ============================================================================
package core_mul_pkg;

    typedef logic [31:0] word_t;
    typedef logic [63:0] dword_t;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_FINISH = 2'd2
    } mul_state_t;

    // Two's-complement magnitude when is_signed is set. The result is read
    // as unsigned, so 0x80000000 becomes 2^31 without overflow.
    function automatic word_t abs_word(input word_t v, input logic is_signed);
        if (is_signed && v[31]) begin
            abs_word = word_t'(-v);
        end else begin
            abs_word = v;
        end
    endfunction

endpackage : core_mul_pkg
`default_nettype wire

// File: rtl/core_mul_fix.sv
`default_nettype none
// ============================================================================
// Module      : core_mul_fix
// Description : Combinational result fix-up for the multiplier FINISH step:
//               optional 64-bit negate of the unsigned product magnitude,
//               followed by an optional 64-bit accumulate (wrapping).
// Ports       : i_prod - 64-bit product magnitude
//               i_neg  - 1 = negate i_prod
//               i_add  - 1 = add i_acc
//               i_acc  - 64-bit accumulator operand
//               o_res  - 64-bit result
// Revision    : 1.0 - initial release
// ============================================================================
module core_mul_fix
    import core_mul_pkg::*;
(
    input  dword_t i_prod,
    input  logic   i_neg,
    input  logic   i_add,
    input  dword_t i_acc,
    output dword_t o_res
);

    dword_t w_signed_prod;

    always_comb begin
        w_signed_prod = i_neg ? dword_t'(-i_prod) : i_prod;
        o_res         = w_signed_prod + (i_add ? i_acc : dword_t'(0));
    end

endmodule : core_mul_fix
`default_nettype wire

// File: rtl/core_mul.sv
`default_nettype none
// ============================================================================
// Module      : core_mul
// Description : Iterative 32x32 multiply / multiply-accumulate responder.
//               Operands are captured on start while ready=1; STEP_BITS
//               multiplier bits are retired per RUN cycle; a single FINISH
//               cycle applies sign and accumulator and writes q.
//               Optional build macro CORE_MUL_EARLY_EXIT_EN: leave RUN as soon
//               as the remaining multiplier magnitude is zero (results are
//               identical, only latency changes).
// Parameters  : STEP_BITS - multiplier bits per RUN cycle (1, 2, 4 or 8)
// Ports       : clk, rst      - clock, synchronous active-high reset
//               start         - request, accepted only while ready=1
//               a, b          - multiplicand, multiplier
//               c_hi, c_lo    - accumulator words (c_hi used in long mode)
//               add           - 1 = add accumulator
//               long_mul      - 1 = accumulator {c_hi,c_lo}, 0 = {0,c_lo}
//               signed_mul    - 1 = a, b are two's complement
//               ready         - idle, q valid
//               q_hi, q_lo    - 64-bit result
// Revision    : 1.0 - initial release
// ============================================================================
module core_mul
    import core_mul_pkg::*;
#(
    parameter int STEP_BITS = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic [31:0] c_hi,
    input  logic [31:0] c_lo,
    input  logic        add,
    input  logic        long_mul,
    input  logic        signed_mul,
    output logic        ready,
    output logic [31:0] q_hi,
    output logic [31:0] q_lo
);

    localparam int         c_steps   = 32 / STEP_BITS;
    localparam logic [5:0] c_steps_w = 6'(c_steps);

    generate
        if (!(STEP_BITS == 1 || STEP_BITS == 2 || STEP_BITS == 4 || STEP_BITS == 8)) begin : g_bad_step
            $error("core_mul: STEP_BITS must be 1, 2, 4 or 8");
        end
    endgenerate

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    mul_state_t state_q, state_d;
    dword_t     a_sh_q,  a_sh_d;   // a_mag pre-shifted to the current digit weight
    word_t      b_rem_q, b_rem_d;  // remaining (unretired) b_mag
    dword_t     sum_q,   sum_d;    // partial sum of the magnitude product
    logic [5:0] cnt_q,   cnt_d;    // RUN cycles completed
    logic       neg_q,   neg_d;
    logic       add_q,   add_d;
    dword_t     acc_q,   acc_d;    // accumulator already widened for the mode
    logic       ready_q, ready_d;
    dword_t     res_q,   res_d;

    dword_t     w_digit;
    dword_t     w_pp;
    dword_t     w_fix_res;
    logic       w_run_done;

    assign w_digit = dword_t'(b_rem_q[STEP_BITS-1:0]);
    assign w_pp    = a_sh_q * w_digit;

    // RUN always spends one extra cycle after the last digit is retired
    // before entering FINISH; the digit seen in that cycle is zero.
`ifdef CORE_MUL_EARLY_EXIT_EN
    // At least one digit is always retired before the zero test applies.
    assign w_run_done = (cnt_q == c_steps_w) || ((cnt_q != 6'd0) && (b_rem_q == '0));
`else
    assign w_run_done = (cnt_q == c_steps_w);
`endif

    core_mul_fix u_fix (
        .i_prod (sum_q),
        .i_neg  (neg_q),
        .i_add  (add_q),
        .i_acc  (acc_q),
        .o_res  (w_fix_res)
    );

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        a_sh_d  = a_sh_q;
        b_rem_d = b_rem_q;
        sum_d   = sum_q;
        cnt_d   = cnt_q;
        neg_d   = neg_q;
        add_d   = add_q;
        acc_d   = acc_q;
        res_d   = res_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    a_sh_d  = {32'h0, abs_word(a, signed_mul)};
                    b_rem_d = abs_word(b, signed_mul);
                    sum_d   = '0;
                    cnt_d   = '0;
                    neg_d   = signed_mul & (a[31] ^ b[31]);
                    add_d   = add;
                    acc_d   = long_mul ? {c_hi, c_lo} : {32'h0, c_lo};
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (w_run_done) begin
                    state_d = ST_FINISH;
                end else begin
                    sum_d   = sum_q + w_pp;
                    a_sh_d  = a_sh_q << STEP_BITS;
                    b_rem_d = b_rem_q >> STEP_BITS;
                    cnt_d   = cnt_q + 6'd1;
                end
            end
            ST_FINISH: begin
                res_d   = w_fix_res;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        ready_d = (state_d == ST_IDLE);
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            a_sh_q  <= '0;
            b_rem_q <= '0;
            sum_q   <= '0;
            cnt_q   <= '0;
            neg_q   <= 1'b0;
            add_q   <= 1'b0;
            acc_q   <= '0;
            ready_q <= 1'b1;
            res_q   <= '0;
        end else begin
            state_q <= state_d;
            a_sh_q  <= a_sh_d;
            b_rem_q <= b_rem_d;
            sum_q   <= sum_d;
            cnt_q   <= cnt_d;
            neg_q   <= neg_d;
            add_q   <= add_d;
            acc_q   <= acc_d;
            ready_q <= ready_d;
            res_q   <= res_d;
        end
    end

    assign ready = ready_q;
    assign q_hi  = res_q[63:32];
    assign q_lo  = res_q[31:0];

endmodule : core_mul
`default_nettype wire

// File: doc/core_mul.md
Name: core_mul

Overview:
- Iterative 32x32 multiply/multiply-accumulate unit.
- Acts as the responder for the core's multiplier handshake: operands arrive with start; the 64-bit result is returned with ready.
- Supports signed/unsigned, short (32-bit) or long (64-bit) accumulate, and a configurable number of multiplier bits retired per cycle.

Parameters:
- STEP_BITS, 2, multiplier bits processed per RUN cycle. Legal values: 1, 2, 4, 8; any other value is an elaboration error. K = 32/STEP_BITS.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high
- start  in  1  request pulse; accepted only while ready=1
- a  in  32  multiplicand
- b  in  32  multiplier
- c_hi  in  32  accumulator high word (long mode only)
- c_lo  in  32  accumulator low word
- add  in  1  1 = add accumulator to product
- long_mul  in  1  1 = 64-bit accumulator {c_hi,c_lo}; 0 = accumulator {32'b0,c_lo}
- signed_mul  in  1  1 = a, b two's complement
- ready  out  1  idle; q valid
- q_hi  out  32  result bits 63:32
- q_lo  out  32  result bits 31:0

Behaviour:
- Interface: one clock (clk), synchronous active-high reset (rst).
- Reset values: state IDLE, ready=1, q_hi=0, q_lo=0, internal registers 0.
- Reset asserted mid-operation aborts the operation; at the next edge the block is IDLE with ready=1 and q=0.
- States:
  - IDLE: ready=1.
    - start=1: latch a, b, c_hi, c_lo, add, long_mul, signed_mul; go to RUN; ready=0 from the next cycle.
  - RUN: each cycle add a_mag*(low STEP_BITS bits of remaining b_mag), shifted, into a 64-bit partial sum; shift remaining b_mag right by STEP_BITS.
    - After K cycles go to FINISH.
  - FINISH: one cycle.
    - Negate the 64-bit partial sum if signed_mul and sign(a)!=sign(b).
    - Add the accumulator if add=1 (64-bit wrap).
    - Write q_hi/q_lo; go to IDLE.
- Magnitudes:
  - signed_mul=0: a_mag=a, b_mag=b.
  - signed_mul=1: absolute values as 32-bit unsigned, so 0x80000000 maps to 2^31 with no overflow.
  - The product magnitude always fits in 64 bits.
- Latency: start sampled at edge 0 → ready=1 with new q at edge K+2. Default STEP_BITS=2 gives 18 edges.
- q_hi/q_lo hold their last value until the FINISH write; during RUN they keep the previous result.
- start while ready=0 is ignored; no queuing.
- Operand inputs are don't-care after the accepting edge.
- start in the same cycle ready returns high is accepted normally; this gives back-to-back operation with no idle bubble.
- Short mode: q = ((product) + (add ? {32'b0,c_lo} : 0)) mod 2^64; q_lo is the architectural result.

Optional Feature:
- CORE_MUL_EARLY_EXIT_EN.
- Defined: after each RUN cycle, if the remaining b_mag is 0, go to FINISH at the next edge. Minimum latency is 3 edges, e.g. for b=0 or |b|<2^STEP_BITS.
- Undefined: fixed K+2 latency for all operands.
- Results are identical either way.

Decomposition:
- core/uarch.sv package:
  - existing word type.
  - dword (64-bit) typedef.
  - mul_state enum {IDLE, RUN, FINISH}.
- Sub-module core_mul_fix (combinational): conditional 64-bit negate plus accumulator add. It is used by FINISH and keeps the FSM file focused on sequencing.

Test Plan:
- Unsigned long, a=b=0xFFFFFFFF, add=0 → q_hi=0xFFFFFFFE, q_lo=0x00000001; ready low for 17 cycles, high at edge 18.
- Signed products:
  - a=0xFFFFFFFE, b=3 → q_hi=0xFFFFFFFF, q_lo=0xFFFFFFFA.
  - a=b=0x80000000 → q_hi=0x40000000, q_lo=0.
- Long accumulate, a=2, b=3, c_hi=0, c_lo=0xFFFFFFFF, add=1 → q_hi=1, q_lo=5.
- Short accumulate, a=b=0x00010000, c_lo=7, c_hi=0xDEADBEEF, add=1 → q_lo=7, q_hi=1 (c_hi ignored).
- Busy, reset and back-to-back:
  - start pulsed again at edge 4 with different operands; a/b changed at edge 1 → result equals the first operands only.
  - rst at RUN cycle 5 → next edge ready=1, q=0; a following 6*7 yields q_lo=42.
  - back-to-back start on the ready edge → second result at edge 36.
- Early exit, b=0 and separately b=1 (a=5):
  - macro defined: ready at edge 3, q_lo=0 and 5 respectively.
  - macro undefined: ready at edge 18, same values.
